// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: machine timer (mtime/mtimecmp), msip and external IRQ register block; `EXT_IRQ_SYNC_EN selects a 2-flop ext_irq_in synchroniser
module timer_irq_ctrl #(
   parameter int TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [4:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic [31:0] bus_rdata,
   output logic        bus_err,
   input  logic        ext_irq_in,
   output logic        timer_irq,
   output logic        soft_irq,
   output logic        ext_irq
);
   logic [15:0] presc;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic        tick;
   logic        wr;
   logic        sel_tlo, sel_thi, sel_clo, sel_chi, sel_sip, hit;
   logic [31:0] rd_val;

   assign sel_tlo = bus_addr == 5'h00;
   assign sel_thi = bus_addr == 5'h04;
   assign sel_clo = bus_addr == 5'h08;
   assign sel_chi = bus_addr == 5'h0C;
   assign sel_sip = bus_addr == 5'h10;
   assign hit     = sel_tlo | sel_thi | sel_clo | sel_chi | sel_sip;
   assign wr      = bus_req & bus_we;
   assign tick    = presc == 16'(TICK_DIV - 1);

   // read mux: unmapped or unaligned addresses read as zero
   always_comb
      rd_val = sel_tlo ? mtime[31:0] :
               sel_thi ? mtime[63:32] :
               sel_clo ? mtimecmp[31:0] :
               sel_chi ? mtimecmp[63:32] :
               sel_sip ? {31'b0, msip} : 32'b0;

   // prescaler: counts 0..TICK_DIV-1 and restarts on any mtime write
   always_ff @(posedge clk)
      if (!reset)
         presc <= '0;
      else if (wr & (sel_tlo | sel_thi))
         presc <= '0;
      else
         presc <= tick ? '0 : presc + 16'd1;

   // mtime: a bus write to either half wins over the tick increment
   always_ff @(posedge clk)
      if (!reset)
         mtime <= '0;
      else if (wr & sel_tlo)
         mtime[31:0] <= bus_wdata;
      else if (wr & sel_thi)
         mtime[63:32] <= bus_wdata;
      else if (tick)
         mtime <= mtime + 64'd1;

   // mtimecmp: one half per write, resets to all ones so no irq fires before software sets it
   always_ff @(posedge clk)
      if (!reset)
         mtimecmp <= '1;
      else if (wr & sel_clo)
         mtimecmp[31:0] <= bus_wdata;
      else if (wr & sel_chi)
         mtimecmp[63:32] <= bus_wdata;

   // msip: only bit 0 is implemented
   always_ff @(posedge clk)
      if (!reset)
         msip <= 1'b0;
      else if (wr & sel_sip)
         msip <= bus_wdata[0];

   // bus response: single-cycle ack carrying the pre-write register value
   always_ff @(posedge clk)
      if (!reset) begin
         bus_ack   <= 1'b0;
         bus_err   <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ack   <= bus_req;
         bus_err   <= bus_req & ~hit;
         bus_rdata <= bus_req ? rd_val : '0;
      end

   // interrupt outputs: registered compare and registered msip
   always_ff @(posedge clk)
      if (!reset) begin
         timer_irq <= 1'b0;
         soft_irq  <= 1'b0;
      end else begin
         timer_irq <= mtime >= mtimecmp;
         soft_irq  <= msip;
      end

`ifdef EXT_IRQ_SYNC_EN
   logic ext_meta;

   // two-flop synchroniser for the asynchronous external line
   always_ff @(posedge clk)
      if (!reset)
         {ext_irq, ext_meta} <= 2'b00;
      else
         {ext_irq, ext_meta} <= {ext_meta, ext_irq_in};
`else
   // single register stage; ext_irq_in is already synchronous to clk
   always_ff @(posedge clk)
      if (!reset)
         ext_irq <= 1'b0;
      else
         ext_irq <= ext_irq_in;
`endif
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: bench for timer_irq_ctrl with TICK_DIV = 1 and TICK_DIV = 3 instances sharing one bus
module tb_timer_irq_ctrl;
`ifdef EXT_IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic        clk;
   logic        reset;
   logic        bus_req;
   logic        bus_we;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic        ext_irq_in;
   logic [1:0]  ack, err, tirq, sirq, eirq;
   logic [31:0] rdata [2];
   int          errors = 0;
   int          checks = 0;

   timer_irq_ctrl #(.TICK_DIV(1)) u0 (
      .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(ack[0]), .bus_rdata(rdata[0]), .bus_err(err[0]),
      .ext_irq_in(ext_irq_in), .timer_irq(tirq[0]), .soft_irq(sirq[0]), .ext_irq(eirq[0]));

   timer_irq_ctrl #(.TICK_DIV(3)) u1 (
      .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(ack[1]), .bus_rdata(rdata[1]), .bus_err(err[1]),
      .ext_irq_in(ext_irq_in), .timer_irq(tirq[1]), .soft_irq(sirq[1]), .ext_irq(eirq[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // behavioural model: architectural registers, outputs predicted one edge ahead
   int          div [2] = '{1, 3};
   logic [63:0] m_time [2];
   int          m_ph [2];
   logic [63:0] m_cmp;
   logic        m_msip, m_ext_d;
   logic        e_ack = 0, e_err = 0, e_soft = 0, e_ext = 0;
   logic        e_irq [2] = '{0, 0};
   logic [31:0] e_rdata [2] = '{0, 0};

   function automatic logic [31:0] reg_val(int k, logic [4:0] a);
      case (a)
         5'h00:   return m_time[k][31:0];
         5'h04:   return m_time[k][63:32];
         5'h08:   return m_cmp[31:0];
         5'h0C:   return m_cmp[63:32];
         5'h10:   return {31'b0, m_msip};
         default: return 32'h0;
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      if (!reset) begin
         m_cmp = '1; m_msip = 0; m_ext_d = 0;
         e_ack = 0; e_err = 0; e_soft = 0; e_ext = 0;
         for (int k = 0; k < 2; k++) begin
            m_time[k] = 0; m_ph[k] = 0; e_irq[k] = 0; e_rdata[k] = 0;
         end
      end else begin
         e_ack  = bus_req;
         e_err  = bus_req && !(bus_addr inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
         e_soft = m_msip;
         e_ext  = (LAT == 1) ? ext_irq_in : m_ext_d;
         m_ext_d = ext_irq_in;
         for (int k = 0; k < 2; k++) begin
            e_irq[k]   = m_time[k] >= m_cmp;
            e_rdata[k] = bus_req ? reg_val(k, bus_addr) : 32'h0;
         end
         if (bus_req && bus_we && bus_addr == 5'h08) m_cmp[31:0] = bus_wdata;
         if (bus_req && bus_we && bus_addr == 5'h0C) m_cmp[63:32] = bus_wdata;
         if (bus_req && bus_we && bus_addr == 5'h10) m_msip = bus_wdata[0];
         for (int k = 0; k < 2; k++) begin
            if (bus_req && bus_we && bus_addr == 5'h00) begin
               m_time[k][31:0] = bus_wdata; m_ph[k] = 0;
            end else if (bus_req && bus_we && bus_addr == 5'h04) begin
               m_time[k][63:32] = bus_wdata; m_ph[k] = 0;
            end else begin
               m_ph[k]++;
               if (m_ph[k] == div[k]) begin
                  m_ph[k] = 0;
                  m_time[k] = m_time[k] + 64'd1;
               end
            end
         end
      end
   end

   // every-cycle comparison of both instances against the model
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ack[%0d]", k), ack[k], e_ack);
            if (e_ack) begin
               chk($sformatf("err[%0d]", k), err[k], e_err);
               chk($sformatf("rdata[%0d]", k), rdata[k], e_rdata[k]);
            end
            chk($sformatf("timer_irq[%0d]", k), tirq[k], e_irq[k]);
            chk($sformatf("soft_irq[%0d]", k), sirq[k], e_soft);
            chk($sformatf("ext_irq[%0d]", k), eirq[k], e_ext);
         end
      end
   end

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      bus_req = 1; bus_we = 1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_req = 0; bus_we = 0;
      chk("wr_ack", ack[0], 1);
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d, output logic e);
      bus_req = 1; bus_we = 0; bus_addr = a;
      @(negedge clk);
      bus_req = 0;
      chk("rd_ack", ack[0], 1);
      d = rdata[0];
      e = err[0];
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      reset = 0; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; ext_irq_in = 0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack[0], 0);
      chk("rst_timer_irq", tirq[0], 0);
      chk("rst_soft_irq", sirq[0], 0);
      chk("rst_ext_irq", eirq[0], 0);
      reset = 1;
      repeat (10) @(negedge clk);
      bus_rd(5'h00, d, e); chk("mtime_lo_after_10", 32'(d >= 9 && d <= 11), 1);
      bus_rd(5'h04, d, e); chk("mtime_hi_after_10", d, 0);
      chk("timer_irq_idle", tirq[0], 0);
      bus_rd(5'h14, d, e); chk("err_0x14", e, 1); chk("rdata_0x14", d, 0);
      bus_rd(5'h02, d, e); chk("err_unaligned", e, 1);
      bus_wr(5'h14, 32'hDEAD_BEEF);
      bus_rd(5'h08, d, e); chk("cmp_lo_reset", d, 32'hFFFF_FFFF); chk("cmp_lo_err", e, 0);
      bus_rd(5'h0C, d, e); chk("cmp_hi_reset", d, 32'hFFFF_FFFF);
      bus_wr(5'h00, 32'hFFFF_FFFE);
      bus_wr(5'h04, 32'h0);
      repeat (2) @(negedge clk);
      bus_rd(5'h00, d, e); chk("carry_lo", d, 0);
      bus_rd(5'h04, d, e); chk("carry_hi", d, 1);
      bus_wr(5'h00, 32'hFFFF_FFFF);
      bus_wr(5'h04, 32'hFFFF_FFFF);
      bus_rd(5'h04, d, e); chk("wrap_hi_before", d, 32'hFFFF_FFFF);
      bus_rd(5'h00, d, e); chk("wrap_lo_after", d, 0);
      bus_rd(5'h04, d, e); chk("wrap_hi_after", d, 0);
      bus_wr(5'h04, 32'h0);
      bus_wr(5'h00, 32'h1C);
      bus_wr(5'h0C, 32'h0);
      bus_wr(5'h08, 32'h20);
      for (int i = 0; i < 20 && !tirq[0]; i++) @(negedge clk);
      chk("timer_irq_rise", tirq[0], 1);
      bus_rd(5'h00, d, e); chk("mtime_at_irq", d, 32'h21);
      bus_wr(5'h0C, 32'hFFFF_FFFF);
      chk("timer_irq_hold", tirq[0], 1);
      @(negedge clk);
      chk("timer_irq_drop", tirq[0], 0);
      bus_wr(5'h10, 32'h3);
      bus_rd(5'h10, d, e); chk("msip_read", d, 1);
      chk("soft_irq_set", sirq[0], 1);
      bus_wr(5'h10, 32'h0);
      chk("soft_irq_hold", sirq[0], 1);
      @(negedge clk);
      chk("soft_irq_clr", sirq[0], 0);
      ext_irq_in = 1;
      @(negedge clk);
      ext_irq_in = 0;
      chk("ext_lat1", eirq[0], 32'(LAT == 1));
      @(negedge clk);
      chk("ext_lat2", eirq[0], 32'(LAT == 2));
      @(negedge clk);
      chk("ext_low", eirq[0], 0);
      reset = 0; bus_req = 1; bus_we = 1; bus_addr = 5'h10; bus_wdata = 1;
      @(negedge clk);
      bus_req = 0; bus_we = 0;
      chk("ack_in_reset", ack[0], 0);
      reset = 1;
      @(negedge clk);
      bus_rd(5'h10, d, e); chk("msip_after_reset", d, 0);
      bus_rd(5'h0C, d, e); chk("cmp_hi_after_reset", d, 32'hFFFF_FFFF);
      bus_wr(5'h00, 32'h100);
      repeat (5) @(negedge clk);
      bus_rd(5'h00, d, e); chk("mtime_resume", d, 32'h105);
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
